// File: rtl/slc3_ctrl_pkg.sv
// slc3_ctrl_pkg: shared FSM state type and debounce default for the SLC-3 run controller.
package slc3_ctrl_pkg;
    localparam int DEBOUNCE_DEFAULT = 16;
    typedef enum logic [1:0] {IDLE, RUNNING, PAUSED, WAIT_REL} run_state_e;
endpackage

// File: rtl/slc3_run_ctrl_button_debounce.sv
// button_debounce: 2-flop synchronizer plus counter debouncer for an active-low pushbutton.
// Emits one-cycle press/release events and the debounced level (1 = released).
module button_debounce
    import slc3_ctrl_pkg::*;
#(
    parameter int CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_ni,
    output logic level_o,
    output logic press_o,
    output logic release_o
);
    localparam int CW = $clog2(CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    logic          sync1_q, sync2_q, db_q, db_d, dly_q, armed_q, armed_d, press_q, rel_q;
    logic [1:0]    settle_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mis, hit;

    // Presses stay masked until the button has been seen released after reset,
    // so a button held through reset cannot launch anything.
    always_comb begin
        mis     = sync2_q != db_q;
        hit     = cnt_q == LAST;
        cnt_d   = (mis && !hit) ? cnt_q + 1'b1 : '0;
        db_d    = (mis && hit) ? sync2_q : db_q;
        armed_d = armed_q | (settle_q[1] & sync2_q & db_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            db_q     <= 1'b1;
            dly_q    <= 1'b1;
            settle_q <= '0;
            armed_q  <= 1'b0;
            cnt_q    <= '0;
            press_q  <= 1'b0;
            rel_q    <= 1'b0;
        end else begin
            sync1_q  <= btn_ni;
            sync2_q  <= sync1_q;
            db_q     <= db_d;
            dly_q    <= db_q;
            settle_q <= {settle_q[0], 1'b1};
            armed_q  <= armed_d;
            cnt_q    <= cnt_d;
            press_q  <= armed_q & dly_q & ~db_q;
            rel_q    <= ~dly_q & db_q;
        end
    end

    assign level_o   = db_q;
    assign press_o   = press_q;
    assign release_o = rel_q;
endmodule

// File: rtl/slc3_run_ctrl.sv
// slc3_run_ctrl: turns debounced Run/Continue buttons into start/resume/abort pulses
// and tracks the CPU run state (IDLE, RUNNING, PAUSED, WAIT_REL).
module slc3_run_ctrl
    import slc3_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic Run,
    input  logic Continue,
    input  logic pause_req,
    output logic start,
    output logic resume,
    output logic abort,
    output logic running,
    output logic paused
);
    run_state_e state_q, state_d;
    logic       run_p, run_lvl, run_rel, cont_p, cont_lvl, cont_rel;
    logic       start_d, resume_d, abort_d;
    logic       unused_evt;

    button_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_run (
        .clk_i(Clk), .rst_ni(Reset_n), .btn_ni(Run),
        .level_o(run_lvl), .press_o(run_p), .release_o(run_rel)
    );

    button_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_cont (
        .clk_i(Clk), .rst_ni(Reset_n), .btn_ni(Continue),
        .level_o(cont_lvl), .press_o(cont_p), .release_o(cont_rel)
    );

    assign unused_evt = run_lvl ^ run_rel ^ cont_rel;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            start   <= 1'b0;
            resume  <= 1'b0;
            abort   <= 1'b0;
        end else begin
            state_q <= state_d;
            start   <= start_d;
            resume  <= resume_d;
            abort   <= abort_d;
        end
    end

    // Run press always wins: it aborts from any active state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     state_d = run_p ? RUNNING : IDLE;
            RUNNING:  state_d = run_p ? IDLE : pause_req ? PAUSED : RUNNING;
            PAUSED:   state_d = run_p ? IDLE : cont_p ? WAIT_REL : PAUSED;
            WAIT_REL: state_d = run_p ? IDLE : (cont_lvl && !pause_req) ? RUNNING : WAIT_REL;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        start_d  = (state_q == IDLE) & run_p;
        abort_d  = (state_q != IDLE) & run_p;
        resume_d = (state_q == PAUSED) & cont_p & ~run_p;
        running  = state_q != IDLE;
        paused   = state_q == PAUSED;
    end
endmodule

// File: tb/tb_slc3_run_ctrl.sv
// tb_slc3_run_ctrl: directed self-checking bench for slc3_run_ctrl with DEBOUNCE_CYCLES = 4.
module tb_slc3_run_ctrl;
    logic clk = 1'b0;
    logic Reset_n = 1'b1;
    logic Run = 1'b1;
    logic Continue = 1'b1;
    logic pause_req = 1'b0;
    logic start, resume, abort, running, paused;
    int   compared = 0;
    int   errs = 0;
    int   n_start = 0, n_resume = 0, n_abort = 0;
    int   s0, r0, a0;

    slc3_run_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
        .Clk(clk), .Reset_n(Reset_n), .Run(Run), .Continue(Continue),
        .pause_req(pause_req), .start(start), .resume(resume), .abort(abort),
        .running(running), .paused(paused)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        n_start  += int'(start);
        n_resume += int'(resume);
        n_abort  += int'(abort);
        compared++;
        assert ($onehot0({start, resume, abort})) else begin
            errs++;
            $error("FAIL onehot: observed %b expected at most one set", {start, resume, abort});
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        compared++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        #2 Reset_n = 1'b0;
        step(2);
        chk("reset_outs", int'({start, resume, abort, running, paused}), 0);
        Reset_n = 1'b1;
        step(5);
        chk("idle_outs", int'({start, resume, abort, running, paused}), 0);
        // Run press from IDLE: start 8 edges after first low sample
        Run = 1'b0;
        step(7);
        chk("start_early", int'(start), 0);
        step(1);
        chk("start_pulse", int'(start), 1);
        chk("running_set", int'(running), 1);
        step(1);
        chk("start_one_cycle", int'(start), 0);
        step(1);
        Run = 1'b1;
        step(12);
        chk("start_count_1", n_start, 1);
        // pause, resume, wait for release
        pause_req = 1'b1;
        step(1);
        chk("paused_set", int'(paused), 1);
        Continue = 1'b0;
        step(7);
        chk("resume_early", int'(resume), 0);
        step(1);
        chk("resume_pulse", int'(resume), 1);
        chk("waitrel_paused", int'(paused), 0);
        chk("waitrel_running", int'(running), 1);
        step(2);
        Continue = 1'b1;
        step(10);
        chk("no_repause", int'(paused), 0);
        pause_req = 1'b0;
        step(1);
        chk("back_running", int'({running, paused}), 2);
        pause_req = 1'b1;
        step(1);
        chk("repause", int'(paused), 1);
        // short Continue glitch is filtered
        r0 = n_resume;
        Continue = 1'b0;
        step(2);
        Continue = 1'b1;
        step(12);
        chk("glitch_paused", int'(paused), 1);
        chk("glitch_no_resume", n_resume, r0);
        // Run and Continue together while PAUSED: abort wins
        Run = 1'b0;
        Continue = 1'b0;
        step(7);
        chk("abort_early", int'(abort), 0);
        step(1);
        chk("abort_pulse", int'({abort, resume}), 2);
        chk("abort_idle", int'({running, paused}), 0);
        step(1);
        chk("abort_one_cycle", int'(abort), 0);
        pause_req = 1'b0;
        Run = 1'b1;
        Continue = 1'b1;
        step(12);
        chk("abort_no_resume", n_resume, r0);
        // both pressed in IDLE: start only
        Run = 1'b0;
        Continue = 1'b0;
        step(8);
        chk("both_idle_start", int'({start, resume, abort}), 4);
        Run = 1'b1;
        Continue = 1'b1;
        step(12);
        chk("both_idle_state", int'({running, paused}), 2);
        // reset mid-RUNNING with Run held
        Run = 1'b0;
        step(4);
        Reset_n = 1'b0;
        #1;
        chk("async_reset_outs", int'({start, resume, abort, running, paused}), 0);
        step(2);
        s0 = n_start;
        a0 = n_abort;
        Reset_n = 1'b1;
        step(20);
        chk("held_no_start", n_start, s0);
        chk("held_no_abort", n_abort, a0);
        chk("held_idle", int'(running), 0);
        Run = 1'b1;
        step(12);
        Run = 1'b0;
        step(8);
        chk("repress_start", int'(start), 1);
        Run = 1'b1;
        step(12);
        Run = 1'b0;
        step(8);
        chk("run_abort", int'({abort, running}), 2);
        Run = 1'b1;
        step(12);
        // long hold yields one start
        s0 = n_start;
        Run = 1'b0;
        step(50);
        chk("long_hold_start", n_start, s0 + 1);
        chk("long_hold_running", int'(running), 1);
        Run = 1'b1;
        step(12);
        chk("total_start", n_start, 4);
        chk("total_resume", n_resume, 1);
        chk("total_abort", n_abort, 2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, errs);
        $finish;
    end
endmodule
